// File: rtl/system_controller_pkg.sv
// system_controller_pkg: shared widths, command opcodes, operand addresses and FSM encoding.
package system_controller_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int REGISTER_FILE_DEPTH = 16;
  localparam int ADDR_WIDTH = $clog2(REGISTER_FILE_DEPTH);
  localparam int ALU_FUNC_WIDTH = 4;
  localparam logic [DATA_WIDTH-1:0] CMD_RF_WR = 8'hAA;
  localparam logic [DATA_WIDTH-1:0] CMD_RF_RD = 8'hBB;
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = 8'hCC;
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD;
  localparam logic [ADDR_WIDTH-1:0] OPERAND_A_ADDR = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OPERAND_B_ADDR = ADDR_WIDTH'(1);
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_WR_ADDR = 4'd1;
  localparam logic [3:0] S_WR_DATA = 4'd2;
  localparam logic [3:0] S_RD_ADDR = 4'd3;
  localparam logic [3:0] S_RD_WAIT = 4'd4;
  localparam logic [3:0] S_OP_A = 4'd5;
  localparam logic [3:0] S_OP_B = 4'd6;
  localparam logic [3:0] S_ALU_FN = 4'd7;
  localparam logic [3:0] S_ALU_WAIT = 4'd8;
  localparam logic [3:0] S_TX_LO = 4'd9;
  localparam logic [3:0] S_TX_LAST = 4'd10;
  typedef enum logic [3:0] {
    IDLE = S_IDLE, WR_ADDR = S_WR_ADDR, WR_DATA = S_WR_DATA, RD_ADDR = S_RD_ADDR,
    RD_WAIT = S_RD_WAIT, OP_A = S_OP_A, OP_B = S_OP_B, ALU_FN = S_ALU_FN,
    ALU_WAIT = S_ALU_WAIT, TX_LO = S_TX_LO, TX_LAST = S_TX_LAST
  } state_t;
endpackage

// File: rtl/system_controller_if.sv
// system_controller_if: UART-side, register-file and ALU signals seen by the command sequencer.
interface system_controller_if;
  import system_controller_pkg::*;
  logic [DATA_WIDTH-1:0] rx_data;
  logic rx_valid;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic rf_rd_valid;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic alu_out_valid;
  logic tx_busy;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic rf_wr_en;
  logic rf_rd_en;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic [ALU_FUNC_WIDTH-1:0] alu_func;
  logic alu_en;
  logic alu_clk_en;
  logic [DATA_WIDTH-1:0] tx_data;
  logic tx_valid;
  modport master (
    input rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_busy,
    output rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_func, alu_en, alu_clk_en, tx_data, tx_valid
  );
  modport slave (
    output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_busy,
    input rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_func, alu_en, alu_clk_en, tx_data, tx_valid
  );
endinterface

// File: rtl/system_controller_tx_byte_sender.sv
// system_controller_tx_byte_sender: holds one byte and runs the tx_valid/tx_busy handshake, pulsing done on acceptance.
module system_controller_tx_byte_sender
  import system_controller_pkg::*;
(
  input  logic ref_clk,
  input  logic reset_n,
  input  logic load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic tx_busy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic tx_valid,
  output logic done
);
  logic pending;
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data <= '0;
      tx_valid <= 1'b0;
      done <= 1'b0;
      pending <= 1'b0;
    end else begin
      done <= tx_valid && tx_busy;
      if (load) begin
        tx_data <= data_in;
        pending <= 1'b1;
        tx_valid <= 1'b0;
      end else if (tx_valid && tx_busy) begin
        tx_valid <= 1'b0;
        pending <= 1'b0;
      end else begin
        tx_valid <= pending && !tx_busy;
      end
    end
  end
endmodule

// File: rtl/system_controller.sv
// system_controller: decodes framed UART commands into RF/ALU strobes and returns results byte by byte.
module system_controller
  import system_controller_pkg::*;
(
  input logic ref_clk,
  input logic reset_n,
  system_controller_if.master bus
);
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, hi_q, hi_d, load_byte;
  logic [ALU_FUNC_WIDTH-1:0] func_q, func_d;
  logic wr_q, wr_d, rd_q, rd_d, go_q, go_d, alu_en_q, clk_en_q, clk_en_d, load, done;
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      hi_q <= '0;
      func_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      go_q <= 1'b0;
      alu_en_q <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      state <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      hi_q <= hi_d;
      func_q <= func_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      go_q <= go_d;
      alu_en_q <= go_q;
      clk_en_q <= clk_en_d;
    end
  end
  always_comb begin
    state_d = state;
    addr_d = addr_q;
    wdata_d = wdata_q;
    hi_d = hi_q;
    func_d = func_q;
    clk_en_d = clk_en_q;
    wr_d = 1'b0;
    rd_d = 1'b0;
    go_d = 1'b0;
    load = 1'b0;
    load_byte = hi_q;
    case (state)
      IDLE: if (bus.rx_valid)
        state_d = bus.rx_data == CMD_RF_WR ? WR_ADDR :
                  bus.rx_data == CMD_RF_RD ? RD_ADDR :
                  bus.rx_data == CMD_ALU_OP ? OP_A :
                  bus.rx_data == CMD_ALU_NOP ? ALU_FN : IDLE;
      WR_ADDR: if (bus.rx_valid) begin
        addr_d = bus.rx_data[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (bus.rx_valid) begin
        wdata_d = bus.rx_data;
        wr_d = 1'b1;
        state_d = IDLE;
      end
      RD_ADDR: if (bus.rx_valid) begin
        addr_d = bus.rx_data[ADDR_WIDTH-1:0];
        rd_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (bus.rf_rd_valid) begin
        load = 1'b1;
        load_byte = bus.rf_rd_data;
        state_d = TX_LAST;
      end
      OP_A, OP_B: if (bus.rx_valid) begin
        addr_d = state == OP_A ? OPERAND_A_ADDR : OPERAND_B_ADDR;
        wdata_d = bus.rx_data;
        wr_d = 1'b1;
        state_d = state == OP_A ? OP_B : ALU_FN;
      end
      ALU_FN: if (bus.rx_valid) begin
        func_d = bus.rx_data[ALU_FUNC_WIDTH-1:0];
        clk_en_d = 1'b1;
        go_d = 1'b1;
        state_d = ALU_WAIT;
      end
      ALU_WAIT: if (bus.alu_out_valid) begin
        hi_d = bus.alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
        load = 1'b1;
        load_byte = bus.alu_out[DATA_WIDTH-1:0];
        clk_en_d = 1'b0;
        state_d = TX_LO;
      end
      TX_LO: if (done) begin
        load = 1'b1;
        state_d = TX_LAST;
      end
      TX_LAST: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.rf_addr = addr_q;
  assign bus.rf_wr_en = wr_q;
  assign bus.rf_rd_en = rd_q;
  assign bus.rf_wr_data = wdata_q;
  assign bus.alu_func = func_q;
  assign bus.alu_en = alu_en_q;
  assign bus.alu_clk_en = clk_en_q;
  system_controller_tx_byte_sender u_tx_byte_sender (
    .ref_clk(ref_clk),
    .reset_n(reset_n),
    .load(load),
    .data_in(load_byte),
    .tx_busy(bus.tx_busy),
    .tx_data(bus.tx_data),
    .tx_valid(bus.tx_valid),
    .done(done)
  );
endmodule

// File: tb/tb_system_controller.sv
// tb_system_controller: directed command vectors against RF/ALU/UART-TX models, plus busy-hold and reset corner cases.
module tb_system_controller;
  import system_controller_pkg::*;
  logic ref_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 ref_clk = ~ref_clk;
  system_controller_if bus();
  system_controller dut (.ref_clk(ref_clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic [31:0] seq;
    int n;
    int wr;
    logic [3:0] wa;
    logic [7:0] wd;
    int rd;
    logic [3:0] ra;
    int alu;
    logic [3:0] fn;
    int ntx;
    logic [7:0] t0;
    logic [7:0] t1;
  } vec_t;
  logic [7:0] rf_m [16];
  logic [7:0] txq [$];
  int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, bad_gate = 0;
  int rd_dly = 0, alu_dly = 0, tx_dly = 0;
  logic force_busy = 1'b0;
  logic [3:0] last_wa = '0, last_ra = '0, last_fn = '0;
  logic [7:0] last_wd = '0;
  logic [15:0] alu_res = '0;
  int n_cmp = 0, n_bad = 0;
  int w0, r0, a0, q0, viol;
  vec_t v [7];
  // Environment: RF answers reads 2 cycles later, ALU answers 3 cycles after alu_en, UART stays busy 6 cycles per byte.
  always @(negedge ref_clk) begin
    bus.rf_rd_valid = 1'b0;
    bus.alu_out_valid = 1'b0;
    if (rd_dly > 0) begin
      rd_dly--;
      if (rd_dly == 0) begin
        bus.rf_rd_valid = 1'b1;
        bus.rf_rd_data = rf_m[last_ra];
      end
    end
    if (alu_dly > 0) begin
      alu_dly--;
      if (alu_dly == 0) begin
        bus.alu_out_valid = 1'b1;
        bus.alu_out = alu_res;
      end
    end
    if (bus.rf_wr_en) begin
      rf_m[bus.rf_addr] = bus.rf_wr_data;
      wr_cnt++;
      last_wa = bus.rf_addr;
      last_wd = bus.rf_wr_data;
    end
    if (bus.rf_rd_en) begin
      rd_cnt++;
      last_ra = bus.rf_addr;
      rd_dly = 2;
    end
    if (bus.alu_en) begin
      alu_cnt++;
      last_fn = bus.alu_func;
      if (!bus.alu_clk_en) bad_gate++;
      case (bus.alu_func)
        4'd0: alu_res = {8'h00, rf_m[0]} + {8'h00, rf_m[1]};
        4'd1: alu_res = {8'h00, rf_m[0]} - {8'h00, rf_m[1]};
        4'd2: alu_res = {8'h00, rf_m[0]} * {8'h00, rf_m[1]};
        default: alu_res = {8'h00, rf_m[0] & rf_m[1]};
      endcase
      alu_dly = 3;
    end
    if (tx_dly > 0) tx_dly--;
    else if (bus.tx_valid && !bus.tx_busy) begin
      txq.push_back(bus.tx_data);
      tx_dly = 6;
    end
    bus.tx_busy = force_busy || tx_dly > 0;
  end
  function automatic vec_t mk(logic [31:0] seq, int n, int wr, logic [3:0] wa, logic [7:0] wd,
                              int rd, logic [3:0] ra, int alu, logic [3:0] fn, int ntx,
                              logic [7:0] t0, logic [7:0] t1);
    vec_t r;
    r.seq = seq; r.n = n; r.wr = wr; r.wa = wa; r.wd = wd; r.rd = rd; r.ra = ra;
    r.alu = alu; r.fn = fn; r.ntx = ntx; r.t0 = t0; r.t1 = t1;
    return r;
  endfunction
  function automatic logic [31:0] outs();
    return {3'b0, bus.rf_addr, bus.rf_wr_en, bus.rf_rd_en, bus.rf_wr_data, bus.alu_func,
            bus.alu_en, bus.alu_clk_en, bus.tx_data, bus.tx_valid};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge ref_clk);
  endtask
  task automatic send(logic [7:0] b);
    @(negedge ref_clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge ref_clk);
    bus.rx_valid = 1'b0;
    cyc(2);
  endtask
  task automatic snap();
    w0 = wr_cnt; r0 = rd_cnt; a0 = alu_cnt; q0 = txq.size();
  endtask
  initial begin
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    v[0] = mk(32'hAA053C00, 3, 1, 4'h5, 8'h3C, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
    v[1] = mk(32'hBB050000, 2, 0, 4'h0, 8'h00, 1, 4'h5, 0, 4'h0, 1, 8'h3C, 8'h00);
    v[2] = mk(32'hCC070300, 4, 2, 4'h1, 8'h03, 0, 4'h0, 1, 4'h0, 2, 8'h0A, 8'h00);
    v[3] = mk(32'hDD020000, 2, 0, 4'h0, 8'h00, 0, 4'h0, 1, 4'h2, 2, 8'h15, 8'h00);
    v[4] = mk(32'h55BB0500, 3, 0, 4'h0, 8'h00, 1, 4'h5, 0, 4'h0, 1, 8'h3C, 8'h00);
    v[5] = mk(32'hAA257700, 3, 1, 4'h5, 8'h77, 0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00);
    v[6] = mk(32'hBB150000, 2, 0, 4'h0, 8'h00, 1, 4'h5, 0, 4'h0, 1, 8'h77, 8'h00);
    cyc(3);
    chk("reset_outputs", outs(), 32'h0);
    reset_n = 1'b1;
    cyc(2);
    for (int i = 0; i < 7; i++) begin
      snap();
      for (int k = 0; k < v[i].n; k++) send(v[i].seq[31-8*k -: 8]);
      cyc(60);
      chk($sformatf("v%0d_wr_pulses", i), wr_cnt - w0, v[i].wr);
      chk($sformatf("v%0d_rd_pulses", i), rd_cnt - r0, v[i].rd);
      chk($sformatf("v%0d_alu_pulses", i), alu_cnt - a0, v[i].alu);
      chk($sformatf("v%0d_tx_count", i), txq.size() - q0, v[i].ntx);
      if (v[i].wr > 0) begin
        chk($sformatf("v%0d_wr_addr", i), last_wa, v[i].wa);
        chk($sformatf("v%0d_wr_data", i), last_wd, v[i].wd);
      end
      if (v[i].rd > 0) chk($sformatf("v%0d_rd_addr", i), last_ra, v[i].ra);
      if (v[i].alu > 0) chk($sformatf("v%0d_alu_func", i), last_fn, v[i].fn);
      if (v[i].ntx > 0) chk($sformatf("v%0d_tx0", i), txq[q0], v[i].t0);
      if (v[i].ntx > 1) chk($sformatf("v%0d_tx1", i), txq[q0+1], v[i].t1);
      chk($sformatf("v%0d_clk_en_low", i), bus.alu_clk_en, 0);
      chk($sformatf("v%0d_tx_valid_low", i), bus.tx_valid, 0);
    end
    chk("alu_en_without_clk_en", bad_gate, 0);
    // Transmitter stuck busy: the read byte must wait, unchanged, without tx_valid.
    force_busy = 1'b1;
    cyc(2);
    send(8'hBB);
    send(8'h05);
    cyc(10);
    viol = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge ref_clk);
      if (bus.tx_valid || bus.tx_data !== 8'h77) viol++;
    end
    chk("busy_hold_violations", viol, 0);
    q0 = txq.size();
    force_busy = 1'b0;
    for (int c = 0; c < 100 && txq.size() == q0; c++) @(negedge ref_clk);
    chk("busy_release_tx_count", txq.size() - q0, 1);
    chk("busy_release_tx_byte", txq[q0], 8'h77);
    cyc(20);
    // Reset in the middle of an RF write: nothing is written and the FSM restarts in IDLE.
    snap();
    send(8'hAA);
    send(8'h05);
    chk("addr_before_reset", bus.rf_addr, 4'h5);
    @(posedge ref_clk);
    #2 reset_n = 1'b0;
    #1 chk("outputs_in_reset", outs(), 32'h0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    send(8'h3C);
    cyc(20);
    chk("no_write_after_reset", wr_cnt - w0, 0);
    snap();
    send(8'hBB);
    send(8'h05);
    cyc(40);
    chk("post_reset_rd_pulses", rd_cnt - r0, 1);
    chk("post_reset_tx_count", txq.size() - q0, 1);
    chk("post_reset_tx_byte", txq[q0], 8'h77);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/system_controller.md
Name: system_controller

Overview:
- Command sequencer in the ref_clk domain, between the UART receiver/transmitter (via synchronizers) and the register file/ALU.
- Decodes framed command bytes:
  - 0xAA: RF write
  - 0xBB: RF read
  - 0xCC: ALU with operands
  - 0xDD: ALU without operands
- Drives RF/ALU strobes and returns results to the UART transmitter one byte at a time, with a busy handshake.

Parameters:
- DATA_WIDTH, 8, UART byte / RF word width
- REGISTER_FILE_DEPTH, 16, RF entries; address width ADDR_WIDTH = clog2(REGISTER_FILE_DEPTH)
- ALU_FUNC_WIDTH, 4, ALU function select width

Ports:
- ref_clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  DATA_WIDTH  received byte, synchronized
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rf_rd_data  in  DATA_WIDTH  RF read data
- rf_rd_valid  in  1  RF read data valid, pulse
- alu_out  in  2*DATA_WIDTH  ALU result
- alu_out_valid  in  1  ALU result valid, pulse
- tx_busy  in  1  transmitter busy, synchronized into ref_clk
- rf_addr  out  ADDR_WIDTH  RF address
- rf_wr_en  out  1  RF write strobe
- rf_rd_en  out  1  RF read strobe
- rf_wr_data  out  DATA_WIDTH  RF write data
- alu_func  out  ALU_FUNC_WIDTH  ALU function
- alu_en  out  1  ALU start strobe
- alu_clk_en  out  1  ALU clock-gate enable
- tx_data  out  DATA_WIDTH  byte to transmit
- tx_valid  out  1  transmit request

Behaviour:
- Reset: all outputs 0, FSM to IDLE, holding registers cleared; takes effect immediately, even mid-command. Any partial command is dropped and any pending TX byte is lost.
- Clocking: all strobes (rf_wr_en, rf_rd_en, alu_en) are single-cycle registered pulses. Outputs are registered.
- Bytes are consumed only on rx_valid; states wait indefinitely for the next byte.
- FSM states and transitions:
  - IDLE:
    - 0xAA -> WR_ADDR
    - 0xBB -> RD_ADDR
    - 0xCC -> OP_A
    - 0xDD -> ALU_FN
    - any other byte is ignored, stay in IDLE
  - WR_ADDR: latch rx_data[ADDR_WIDTH-1:0] -> WR_DATA.
  - WR_DATA: next cycle pulse rf_wr_en with the latched addr/data -> IDLE.
  - RD_ADDR: latch addr, pulse rf_rd_en -> RD_WAIT.
  - RD_WAIT: on rf_rd_valid, load tx_data = rf_rd_data -> TX_LAST.
  - OP_A: write byte to RF address 0 (rf_wr_en pulse) -> OP_B.
  - OP_B: write byte to RF address 1 -> ALU_FN.
  - ALU_FN:
    - latch rx_data[ALU_FUNC_WIDTH-1:0] into alu_func
    - assert alu_clk_en; pulse alu_en one cycle later
    - -> ALU_WAIT
  - ALU_WAIT: on alu_out_valid, register alu_out; tx_data = low byte -> TX_LO.
  - TX_LO:
    - handshake completes -> tx_data = high byte -> TX_LAST.
  - TX_LAST:
    - handshake completes -> IDLE.
- alu_clk_en: asserted from ALU_FN through ALU_WAIT; deasserted on entering TX_LO.
- TX handshake:
  - tx_valid is asserted only while tx_busy = 0.
  - tx_data is held stable while tx_valid is high.
  - tx_valid drops the cycle after tx_busy is seen high.
  - The next byte waits for tx_busy to return to 0.
- Byte order: ALU result is sent low byte first, then high byte.
- Operands A/B are always RF[0]/RF[1]; 0xDD reuses their current contents.
- Address width: addresses >= REGISTER_FILE_DEPTH are truncated to ADDR_WIDTH bits (wrap).
- rx_valid arriving in RD_WAIT, ALU_WAIT, TX_LO or TX_LAST is ignored (byte dropped).
- Simultaneous rx_valid with a returning handshake: the handshake wins and the byte is ignored.

Decomposition:
- Shared package holds:
  - command opcodes CMD_RF_WR = 8'hAA, CMD_RF_RD = 8'hBB, CMD_ALU_OP = 8'hCC, CMD_ALU_NOP = 8'hDD
  - operand addresses OPERAND_A_ADDR = 0, OPERAND_B_ADDR = 1
  - state encoding localparams
- One sub-module: tx_byte_sender, which implements the tx_valid/tx_busy handshake and byte holding. The FSM hands it a byte plus a load pulse and gets back a done pulse.

Test Plan:
- RF write: AA, 05, 3C -> one rf_wr_en pulse with rf_addr = 5, rf_wr_data = 0x3C; no tx_valid.
- RF read: AA 05 3C, then BB, 05 -> rf_rd_en with addr 5; tx_data = 0x3C sent once; FSM back in IDLE.
- ALU with operands: CC, 07, 03, 00 (add) ->
  - RF[0] = 0x07, RF[1] = 0x03, alu_func = 0, alu_en pulse
  - tx bytes 0x0A then 0x00; alu_clk_en low afterwards
- ALU without operands, following the above: DD, 02 (mult) -> tx bytes 0x15 then 0x00; no RF writes.
- Robustness:
  - 0x55 in IDLE -> ignored; a following BB 05 works normally
  - tx_busy held high 1000 cycles -> tx_valid stays low and tx_data is unchanged until tx_busy falls
- Reset mid-command: AA, 05, then reset_n low -> all outputs 0 immediately, no rf_wr_en; a subsequent BB 05 executes cleanly.
